button_event_arbiter: RTL and testbench

Front-end controller for the user push-buttons. It synchronizes and debounces N raw button inputs using one shared sample-tick counter. Each clean press (rising debounced edge) becomes a pending event. Pending events are arbitrated round-robin onto a single valid/ready event port, which feeds the top-level control FSM.

---
 rtl/button_event_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
// Button front end: 2-flop sync, shared-tick debounce, press capture and a
// round-robin valid/ready event port. Optional auto-repeat: BTN_AUTOREPEAT_EN.
//
// state    | meaning
// ST_IDLE  | no event offered; grant the next pending button, if any
// ST_OFFER | evt_valid high, evt_id frozen until evt_ready
module button_event_arbiter #(
  parameter int N_BTN          = 4,
  parameter int SAMPLE_DIV     = 65536,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_TICKS   = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_in,
  output logic                     evt_valid,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic [N_BTN-1:0]         btn_level,
  output logic                     evt_overrun
);

  localparam int ID_W   = $clog2(N_BTN);
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [3:0]        CNT_LAST  = 4'(STABLE_SAMPLES - 1);
  localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(N_BTN - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_OFFER} state_t;

  state_t            state_q, state_d;
  logic [N_BTN-1:0]  sync1_q, sync1_d;
  logic [N_BTN-1:0]  sync2_q, sync2_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [N_BTN-1:0]  level_q, level_d;
  logic [3:0]        cnt_q [N_BTN];
  logic [3:0]        cnt_d [N_BTN];
  logic [N_BTN-1:0]  pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;

  logic              tick;
  logic [N_BTN-1:0]  press;
  logic [N_BTN-1:0]  new_evt;
  logic [N_BTN-1:0]  grant_vec;
  logic [N_BTN-1:0]  pending_clr;
  logic              found;
  int                cand;

  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    tick    = (tick_q == TICK_LAST);
    tick_d  = tick ? '0 : tick_q + TICK_W'(1);
  end

  // A level flips only after STABLE_SAMPLES consecutive disagreeing ticks.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] == level_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
    press = level_d & ~level_q;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);

  logic [RPT_W-1:0] rpt_q [N_BTN];
  logic [RPT_W-1:0] rpt_d [N_BTN];
  logic [N_BTN-1:0] rpt_evt;

  // Counter holds at zero while released, so it restarts on every press edge.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      rpt_d[i]   = rpt_q[i];
      rpt_evt[i] = 1'b0;
      if (!level_q[i]) begin
        rpt_d[i] = '0;
      end else if (tick) begin
        if (rpt_q[i] == RPT_LAST) begin
          rpt_evt[i] = level_d[i];
          rpt_d[i]   = '0;
        end else begin
          rpt_d[i] = rpt_q[i] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '{default: '0};
    end else begin
      rpt_q <= rpt_d;
    end
  end

  assign new_evt = press | rpt_evt;
`else
  assign new_evt = press;
`endif

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    id_d      = id_q;
    last_d    = last_q;
    grant_vec = '0;
    found     = 1'b0;
    cand      = 0;
    case (state_q)
      ST_IDLE: begin
        for (int k = 1; k <= N_BTN; k++) begin
          cand = (int'(last_q) + k) % N_BTN;
          if (!found && pending_q[cand]) begin
            found           = 1'b1;
            id_d            = ID_W'(cand);
            grant_vec[cand] = 1'b1;
          end
        end
        if (found) begin
          valid_d = 1'b1;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          valid_d = 1'b0;
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Grant clears first, so a press on the button just granted re-arms it legally.
  always_comb begin
    pending_clr = pending_q & ~grant_vec;
    pending_d   = pending_clr | new_evt;
    overrun_d   = overrun_q | (|(pending_clr & new_evt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      tick_q    <= '0;
      level_q   <= '0;
      cnt_q     <= '{default: '0};
      pending_q <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= LAST_INIT;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      tick_q    <= tick_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      last_q    <= last_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_id      = id_q;
  assign btn_level   = level_q;
  assign evt_overrun = overrun_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench for button_event_arbiter: tick-level debounce model plus
// round-robin event model; a negedge monitor pops expected ids on each handshake.
module tb_button_event_arbiter;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int SS = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready = 1'b0;
  logic [N-1:0] btn_level;
  logic         evt_overrun;

  button_event_arbiter #(
    .N_BTN(N), .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS), .REPEAT_TICKS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .evt_valid(evt_valid),
    .evt_id(evt_id), .evt_ready(evt_ready), .btn_level(btn_level),
    .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // reference model state
  logic [N-1:0] m_level;
  logic [N-1:0] m_pending;
  logic         m_overrun;
  int           m_off;
  int           m_last;
  int           edge_n;
  bit           hist [N][$];
  int           expq [$];

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic model_reset();
    m_level = '0; m_pending = '0; m_overrun = 1'b0;
    m_off = -1; m_last = N - 1; edge_n = 0;
    for (int i = 0; i < N; i++) hist[i].delete();
    expq.delete();
  endtask

  // Called right at a posedge with the inputs the DUT just sampled.
  task automatic model_step();
    bit all_diff;
    edge_n++;
    if (m_off >= 0) begin
      if (evt_ready) begin
        m_last = m_off;
        m_off  = -1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (m_off < 0 && m_pending[c]) begin
          m_off = c;
          m_pending[c] = 1'b0;
          expq.push_back(c);
        end
      end
    end
    if (edge_n % SD == 0) begin
      for (int i = 0; i < N; i++) begin
        hist[i].push_back(btn_in[i]);
        if (hist[i].size() > SS) void'(hist[i].pop_front());
        all_diff = (hist[i].size() == SS);
        foreach (hist[i][j]) if (hist[i][j] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[i] = ~m_level[i];
          hist[i].delete();
          if (m_level[i]) begin
            if (m_pending[i]) m_overrun = 1'b1;
            m_pending[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("evt_valid", int'(evt_valid), int'(m_off >= 0));
    if (m_off >= 0) check("offer_id", int'(evt_id), m_off);
    if (edge_n % SD == 0) begin
      check("btn_level", int'(btn_level), int'(m_level));
      check("evt_overrun", int'(evt_overrun), int'(m_overrun));
    end
  endtask

  // ready_mode: 0 = low, 1 = high, 2 = random per cycle
  task automatic run(int ticks, int ready_mode);
    for (int c = 0; c < ticks * SD; c++) begin
      cycle();
      if (ready_mode == 2) evt_ready = 1'($urandom_range(0, 1));
      else evt_ready = 1'(ready_mode);
    end
  endtask

  task automatic press_release(logic [N-1:0] pat, int ready_mode);
    btn_in = pat;
    run(5, ready_mode);
    btn_in = '0;
    run(4, ready_mode);
  endtask

  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (expq.size() == 0) check("evt_unexpected", int'(evt_id), -1);
      else check("evt_order", int'(evt_id), expq.pop_front());
    end
  end

  initial begin
    int got;
    model_reset();
    btn_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(evt_valid), 0);
    check("rst_id", int'(evt_id), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_overrun", int'(evt_overrun), 0);
    rst_n = 1'b1;
    evt_ready = 1'b1;

    // all four held from reset: levels rise at tick 3, events 0,1,2,3
    run(8, 1);
    btn_in = '0;
    run(4, 1);

    press_release(4'b0100, 1);
    // bounce on button 1: 1,0,1,1,0
    btn_in = 4'b0010; run(1, 1);
    btn_in = 4'b0000; run(1, 1);
    btn_in = 4'b0010; run(2, 1);
    btn_in = 4'b0000; run(4, 1);

    press_release(4'b1011, 1);
    press_release(4'b1001, 1);
    press_release(4'b0010, 1);
    press_release(4'b1010, 1);

    // backpressure: offer 0 held, two re-presses, second overruns
    evt_ready = 1'b0;
    press_release(4'b0001, 0);
    press_release(4'b0001, 0);
    press_release(4'b0001, 0);
    run(6, 1);

    for (int it = 0; it < 200; it++) begin
      btn_in = 4'($urandom_range(0, 15));
      run($urandom_range(1, 5), $urandom_range(0, 2));
    end
    btn_in = '0;
    run(6, 1);
    check("queue_drained", expq.size(), 0);

    // async reset in the middle of an offer
    evt_ready = 1'b0;
    btn_in = 4'b0100;
    got = 0;
    for (int c = 0; c < 200 && got == 0; c++) begin
      cycle();
      if (m_off >= 0) got = 1;
    end
    check("offer_reached", got, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", int'(evt_valid), 0);
    check("arst_level", int'(btn_level), 0);
    check("arst_overrun", int'(evt_overrun), 0);
    btn_in = '0;
    evt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    run(10, 1);
    check("post_reset_queue", expq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
